// File: rtl/grid_pkg.sv
// Shared types and row selection for the life-grid transmit path.
// Row 0 is the most-significant COLS bits of the grid word.
package grid_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;

  typedef logic [GRID_COLS-1:0]           row_t;
  typedef logic [GRID_ROWS*GRID_COLS-1:0] grid_t;
  typedef logic [$clog2(GRID_ROWS)-1:0]   row_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  function automatic row_t get_row(input grid_t g, input row_idx_t r);
    return row_t'(g >> ((GRID_ROWS - 1 - int'(r)) * GRID_COLS));
  endfunction

endpackage

// File: rtl/grid_row_tx.sv
// Snapshots each new generation and streams it one row per beat with sof/eof.
// Define GRID_SKIP_STABLE_EN to suppress frames for captures equal to the previous one.
module grid_row_tx
  import grid_pkg::*;
#(
  parameter int ROWS  = GRID_ROWS,
  parameter int COLS  = GRID_COLS,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [ROWS*COLS-1:0]    grid_in,
  input  logic                    grid_valid,
  output logic                    grid_ready,
  output logic [COLS-1:0]         tx_data,
  output logic [$clog2(ROWS)-1:0] tx_row,
  output logic                    tx_sof,
  output logic                    tx_eof,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [GEN_W-1:0]        gen_count,
  output logic                    stable,
  output logic                    busy
);

  tx_state_e        state_q, state_d;
  grid_t            snap_q;
  row_idx_t         row_q;
  logic [GEN_W-1:0] gen_q;
  logic             prev_valid_q;
  logic             stable_q;

  logic capture, same, send_frame, beat_done, last_row;

  // The snapshot register doubles as the previous snapshot for the next compare.
  assign capture   = grid_valid && (state_q == IDLE) && !clear;
  assign same      = prev_valid_q && (grid_in == snap_q);
  assign last_row  = (row_q == row_idx_t'(GRID_ROWS - 1));
  assign beat_done = (state_q == SEND) && tx_ready;

`ifdef GRID_SKIP_STABLE_EN
  assign send_frame = capture && !same;
`else
  assign send_frame = capture;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (send_frame)            state_d = SEND;
        SEND: if (tx_ready && last_row)  state_d = IDLE;
        default:                         state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the snapshot is a plain register bank, not a memory, so it is safe to reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q       <= '0;
      row_q        <= '0;
      gen_q        <= '0;
      prev_valid_q <= 1'b0;
      stable_q     <= 1'b0;
    end else if (clear) begin
      snap_q       <= '0;
      row_q        <= '0;
      gen_q        <= '0;
      prev_valid_q <= 1'b0;
      stable_q     <= 1'b0;
    end else begin
      if (capture) begin
        snap_q       <= grid_in;
        row_q        <= '0;
        gen_q        <= gen_q + GEN_W'(1);
        stable_q     <= same;
        prev_valid_q <= 1'b1;
      end
      // Row index wraps back to 0 after the last beat, ready for the next frame.
      if (beat_done) row_q <= row_q + row_idx_t'(1);
    end
  end

  assign grid_ready = (state_q == IDLE);
  assign tx_valid   = (state_q == SEND);
  assign busy       = tx_valid;
  assign tx_data    = get_row(snap_q, row_q);
  assign tx_row     = row_q;
  assign tx_sof     = tx_valid && (row_q == '0);
  assign tx_eof     = tx_valid && last_row;
  assign gen_count  = gen_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_grid_row_tx.sv
// Scoreboard bench for grid_row_tx: a frame model queues expected beats, a monitor pops them.
// A second instance with a 2-bit generation counter shares all stimulus to exercise wrap.
module tb_grid_row_tx;
  import grid_pkg::*;

  logic clk = 1'b0;
  logic reset, clear, grid_valid, tx_ready;
  grid_t grid_in;

  logic       grid_ready, tx_sof, tx_eof, tx_valid, stable, busy;
  logic [7:0] tx_data;
  logic [2:0] tx_row;
  logic [15:0] gen_count;

  logic       grid_ready_w, tx_sof_w, tx_eof_w, tx_valid_w, stable_w, busy_w;
  logic [7:0] tx_data_w;
  logic [2:0] tx_row_w;
  logic [1:0] gen_count_w;

  grid_row_tx #(.ROWS(8), .COLS(8), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(grid_ready), .tx_data(tx_data), .tx_row(tx_row), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .tx_valid(tx_valid), .tx_ready(tx_ready), .gen_count(gen_count),
    .stable(stable), .busy(busy)
  );

  grid_row_tx #(.ROWS(8), .COLS(8), .GEN_W(2)) dut_w (
    .clk(clk), .reset(reset), .clear(clear), .grid_in(grid_in), .grid_valid(grid_valid),
    .grid_ready(grid_ready_w), .tx_data(tx_data_w), .tx_row(tx_row_w), .tx_sof(tx_sof_w),
    .tx_eof(tx_eof_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready), .gen_count(gen_count_w),
    .stable(stable_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] row;
    logic       sof;
    logic       eof;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int unsigned m_gen;
  logic        m_stable, m_prev_valid;
  grid_t       m_prev;
  int          ready_mode;

  localparam grid_t BASIC = 64'h0412_6424_0034_3C28;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: compares every presented beat with the queue head, pops on handshake.
  always @(negedge clk) begin
    if (reset && tx_valid) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_beat");
      end else begin
        check("beat", {tx_data, tx_row, tx_sof, tx_eof}, exp_q[0]);
        check("beat_w", {tx_data_w, tx_row_w, tx_sof_w, tx_eof_w}, exp_q[0]);
        check("busy_ready", {busy, grid_ready}, 2'b10);
        if (tx_ready) void'(exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic model_reset();
    exp_q.delete();
    m_gen = 0;
    m_stable = 1'b0;
    m_prev_valid = 1'b0;
    m_prev = '0;
  endtask

  task automatic send_grid(input grid_t g);
    int  n = 0;
    bit  skip;
    @(posedge clk); #1;
    while (!grid_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!grid_ready) fail("grid_ready_timeout");
    grid_in = g;
    grid_valid = 1'b1;
    @(posedge clk); #1;
    grid_valid = 1'b0;
    grid_in = {$urandom, $urandom};
    m_stable = m_prev_valid && (g == m_prev);
    m_prev = g;
    m_prev_valid = 1'b1;
    m_gen++;
`ifdef GRID_SKIP_STABLE_EN
    skip = m_stable;
`else
    skip = 1'b0;
`endif
    if (!skip) begin
      for (int r = 0; r < 8; r++) begin
        beat_t b;
        b.data = 8'((g >> (8 * (7 - r))) & 64'hFF);
        b.row  = 3'(r);
        b.sof  = (r == 0);
        b.eof  = (r == 7);
        exp_q.push_back(b);
      end
    end
    @(negedge clk);
    check("gen_count", gen_count, 64'(m_gen % 65536));
    check("gen_count_w", gen_count_w, 64'(m_gen % 4));
    check("stable", stable, m_stable);
    check("first_beat_valid", tx_valid, !skip);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (!(exp_q.size() == 0 && grid_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(exp_q.size() == 0 && grid_ready)) fail("frame_end_timeout");
  endtask

  task automatic wait_row(input logic [2:0] r);
    int n = 0;
    @(posedge clk); #1;
    while (!(tx_valid && tx_row == r) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(tx_valid && tx_row == r)) fail("wait_row_timeout");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    grid_t g, last;
    reset = 1'b0; clear = 1'b0; grid_valid = 1'b0; tx_ready = 1'b1;
    grid_in = '0; ready_mode = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {grid_ready, tx_valid, busy, stable, tx_sof, tx_eof, tx_data, tx_row},
          {1'b1, 5'b0, 8'h00, 3'd0});
    check("reset_gen", gen_count, 0);
    reset = 1'b1;

    // Basic frame, then four more captures to walk the 2-bit counter through its wrap.
    send_grid(BASIC);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      send_grid({$urandom, $urandom});
      wait_idle();
    end

    // Backpressure on alternate cycles
    ready_mode = 1;
    send_grid(BASIC);
    wait_idle();

    // Stable detect
    ready_mode = 0;
    g = {$urandom, $urandom};
    send_grid(g);
    wait_idle();
    send_grid(g);
    wait_idle();

    // New grid presented mid-frame must be ignored
    send_grid(BASIC);
    wait_row(3'd3);
    grid_in = '1;
    grid_valid = 1'b1;
    @(posedge clk); #1;
    grid_valid = 1'b0;
    check("ignored_gen_count", gen_count, 64'(m_gen % 65536));
    wait_idle();

    // Clear at beat 4
    send_grid(BASIC);
    wait_row(3'd4);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_state", {tx_valid, busy, stable, grid_ready}, 4'b0001);
    check("clear_gen", gen_count, 0);
    check("clear_gen_w", gen_count_w, 0);
    model_reset();
    send_grid(BASIC);
    wait_idle();

    // Asynchronous reset at beat 4, checked before the next clock edge
    send_grid(BASIC);
    wait_row(3'd4);
    #2 reset = 1'b0;
    #1;
    check("areset_state", {tx_valid, busy, stable, tx_sof, tx_eof, grid_ready}, 6'b000001);
    check("areset_data", {tx_data, tx_row}, 0);
    check("areset_gen", gen_count, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    send_grid(BASIC);
    wait_idle();

    // Randomized traffic with occasional repeated grids
    last = BASIC;
    for (int i = 0; i < 30; i++) begin
      ready_mode = int'($urandom_range(0, 2));
      g = ($urandom_range(0, 3) == 0) ? last : {$urandom, $urandom};
      send_grid(g);
      wait_idle();
      last = g;
    end

    ready_mode = 0;
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) fail("leftover_beats");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
